// File: rtl/morph_pkg.sv
// Shared definitions for the morph_filter binary morphology engine:
// FSM state encoding, operating-mode codes and the fill values used
// for neighbours that fall outside the image.
package morph_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PASS = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_DILATE = 2'd0;
    localparam logic [1:0] MODE_ERODE  = 2'd1;
    localparam logic [1:0] MODE_OPEN   = 2'd2;
    localparam logic [1:0] MODE_CLOSE  = 2'd3;

    // A missing neighbour must not change the result, so it takes the
    // identity value of the reduction: 0 for OR (dilate), 1 for AND (erode).
    localparam logic FILL_DILATE = 1'b0;
    localparam logic FILL_ERODE  = 1'b1;

    function automatic logic fill_bit(input logic erode);
        return erode ? FILL_ERODE : FILL_DILATE;
    endfunction

endpackage

// File: rtl/morph_row.sv
// Combinational single-row morphology kernel.
// Produces one output row from the rows above, at and below it. The
// caller supplies fill rows for the top/bottom image edges; left/right
// edges are handled here per column (no wrap between column 0 and W-1).
// Build option MORPH_SQUARE_KERNEL_EN: 3x3 square element (diagonals of
// up/down rows included); otherwise a 4-neighbour cross.
module morph_row
    import morph_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] up_i,
    input  logic [W-1:0] centre_i,
    input  logic [W-1:0] down_i,
    input  logic         erode_i,
    output logic [W-1:0] row_o
);

    logic fill;
    assign fill = fill_bit(erode_i);

    for (genvar c = 0; c < W; c++) begin : g_col
        logic lft;
        logic rgt;

        if (c == 0) begin : g_lft_edge
            assign lft = fill;
        end else begin : g_lft_in
            assign lft = centre_i[c-1];
        end

        if (c == W - 1) begin : g_rgt_edge
            assign rgt = fill;
        end else begin : g_rgt_in
            assign rgt = centre_i[c+1];
        end

`ifdef MORPH_SQUARE_KERNEL_EN
        logic up_l;
        logic up_r;
        logic dn_l;
        logic dn_r;

        if (c == 0) begin : g_diag_l_edge
            assign up_l = fill;
            assign dn_l = fill;
        end else begin : g_diag_l_in
            assign up_l = up_i[c-1];
            assign dn_l = down_i[c-1];
        end

        if (c == W - 1) begin : g_diag_r_edge
            assign up_r = fill;
            assign dn_r = fill;
        end else begin : g_diag_r_in
            assign up_r = up_i[c+1];
            assign dn_r = down_i[c+1];
        end

        assign row_o[c] = erode_i
            ? &{centre_i[c], up_i[c], down_i[c], lft, rgt, up_l, up_r, dn_l, dn_r}
            : |{centre_i[c], up_i[c], down_i[c], lft, rgt, up_l, up_r, dn_l, dn_r};
`else
        assign row_o[c] = erode_i
            ? &{centre_i[c], up_i[c], down_i[c], lft, rgt}
            : |{centre_i[c], up_i[c], down_i[c], lft, rgt};
`endif
    end

endmodule

// File: rtl/morph_filter.sv
// Iterative binary morphology engine (dilate / erode / open / close).
// Loads a W x H 1-bit image into a single working buffer and rewrites it
// in place one row per clock, keeping the original previous row in a
// one-row register so the next row still sees pre-pass data.
// Build option MORPH_SQUARE_KERNEL_EN selects a 3x3 square structuring
// element in morph_row; the default is a 4-neighbour cross. Timing is the
// same in both builds.
module morph_filter
    import morph_pkg::*;
#(
    parameter int W      = 32,
    parameter int H      = 32,
    parameter int ITER_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ITER_W-1:0]   iter,
    input  logic [W*H-1:0]      in_image,
    output logic                busy,
    output logic                done,
    output logic                out_valid,
    output logic [W*H-1:0]      out_image,
    output logic [W*H-1:0]      show_image
);

    localparam int ROW_W  = (H > 1) ? $clog2(H) : 1;
    localparam int PASS_W = ITER_W + 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(H - 1);

    state_t              state_q;
    logic [1:0]          mode_q;
    logic [ITER_W-1:0]   iter_q;
    logic [PASS_W-1:0]   passes_q;
    logic [PASS_W-1:0]   pass_q;
    logic [ROW_W-1:0]    row_q;
    logic                busy_q;
    logic                done_q;
    logic                valid_q;

    logic [H-1:0][W-1:0] img_q;
    logic [W-1:0]        prev_q;

    logic [PASS_W-1:0]   passes_d;
    logic                erode;
    logic                last_pass;
    logic [ROW_W-1:0]    row_dn;
    logic [W-1:0]        up_row;
    logic [W-1:0]        centre_row;
    logic [W-1:0]        down_row;
    logic [W-1:0]        result_row;

    // Total pass count: open/close run iter passes of each operator.
    always_comb begin
        passes_d = {1'b0, iter_q};
        if (mode_q == MODE_OPEN || mode_q == MODE_CLOSE) begin
            passes_d = {iter_q, 1'b0};
        end
    end

    // Operator for the current pass; compound modes switch after iter passes.
    always_comb begin
        erode = 1'b0;
        case (mode_q)
            MODE_DILATE: erode = 1'b0;
            MODE_ERODE:  erode = 1'b1;
            MODE_OPEN:   erode = (pass_q < {1'b0, iter_q});
            MODE_CLOSE:  erode = !(pass_q < {1'b0, iter_q});
            default:     erode = 1'b0;
        endcase
    end

    // Neighbour rows for the row engine; image top/bottom use the fill row.
    always_comb begin
        row_dn     = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
        centre_row = img_q[row_q];
        up_row     = (row_q == '0) ? {W{fill_bit(erode)}} : prev_q;
        down_row   = (row_q == LAST_ROW) ? {W{fill_bit(erode)}} : img_q[row_dn];
    end

    assign last_pass = ((pass_q + PASS_W'(1)) == passes_q);

    morph_row #(
        .W (W)
    ) u_row (
        .up_i     (up_row),
        .centre_i (centre_row),
        .down_i   (down_row),
        .erode_i  (erode),
        .row_o    (result_row)
    );

    // Control FSM with registered busy/done/out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= MODE_DILATE;
            iter_q   <= '0;
            passes_q <= '0;
            pass_q   <= '0;
            row_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        iter_q  <= iter;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    valid_q  <= 1'b0;
                    passes_q <= passes_d;
                    pass_q   <= '0;
                    row_q    <= '0;
                    if (passes_d == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= PASS;
                    end
                end
                PASS: begin
                    if (row_q == LAST_ROW) begin
                        row_q <= '0;
                        if (last_pass) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            pass_q <= pass_q + PASS_W'(1);
                        end
                    end else begin
                        row_q <= row_q + ROW_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Working buffer: bulk load, then in-place row rewrite saving the original row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_q  <= '0;
            prev_q <= '0;
        end else if (state_q == LOAD) begin
            img_q  <= in_image;
        end else if (state_q == PASS) begin
            img_q[row_q] <= result_row;
            prev_q       <= centre_row;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign out_valid  = valid_q;
    assign show_image = img_q;

    // DNN vector is bit-reversed relative to pixel index.
    for (genvar i = 0; i < W * H; i++) begin : g_rev
        assign out_image[W*H-1-i] = img_q[i/W][i%W];
    end

endmodule
